// File: rtl/prio_sel_pipe_pkg.sv
// Shared types for prio_sel_pipe.
// Stage payload is sized for the widest supported build. Each instance uses the low bits.
// Port summary: none (package).
package prio_sel_pipe_pkg;

  // Upper bounds on the payload fields: channel width up to 64 bits,
  // and up to 16 channels (4-bit index).
  localparam int PL_DW = 64;
  localparam int PL_IW = 4;

  // Step applied by the saturating bypass counter.
  localparam int unsigned SAT_INC = 1;

  // Beat as captured by stage 1.
  typedef struct packed {
    logic [PL_DW-1:0] data;      // selected channel data, or dflt on no hit
    logic [PL_IW-1:0] idx;       // lowest set sel index (0 on no hit)
    logic             hit;       // some sel bit was set
    logic             byp_en;    // bypass requested with this beat
    logic [PL_DW-1:0] byp_data;  // bypass value carried alongside
  } stage_pl_t;

endpackage

// File: rtl/prio_sel_pipe_prio_enc.sv
// prio_enc: combinational lowest-index-wins priority encoder.
// Ports: sel[N] in; idx[$clog2(N)] out (0 when no bit is set); hit out.
// Bit 0 has the highest priority.
module prio_enc
  import prio_sel_pipe_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         sel,
  output logic [$clog2(N)-1:0] idx,
  output logic                 hit
);

  localparam int IW = $clog2(N);

  // Scan from the top down so that the lowest set bit is the last to overwrite.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) begin
        idx = IW'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_sel_pipe.sv
// prio_sel_pipe: two-stage priority select with a late-vetoable bypass and a saturating bypass counter.
// Ports: in_valid/in_ready + sel/data/dflt/byp_en/byp_data beat in; late_ctrl veto sampled as a beat leaves stage 1;
//        out_valid/out_ready + out_data/out_idx/out_hit/out_byp out; byp_cnt counts delivered bypassed results.
module prio_sel_pipe
  import prio_sel_pipe_pkg::*;
#(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int BYP_MIN = 2,
  parameter int CW      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         sel,
  input  logic [N*W-1:0]       data,
  input  logic [W-1:0]         dflt,
  input  logic                 byp_en,
  input  logic [W-1:0]         byp_data,
  input  logic                 late_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_hit,
  output logic                 out_byp,
  output logic [CW-1:0]        byp_cnt
);

  localparam int IW = $clog2(N);

  // ---------------- stage 1 capture ----------------
  logic [IW-1:0] enc_idx;
  logic          enc_hit;
  logic [W-1:0]  ch_data;

  prio_enc #(.N(N)) u_prio_enc (
    .sel (sel),
    .idx (enc_idx),
    .hit (enc_hit)
  );

  assign ch_data = enc_hit ? data[int'(enc_idx)*W +: W] : dflt;

  stage_pl_t s1_d;
  stage_pl_t s1_q;
  logic      v1;
  logic      v2;

  always_comb begin
    s1_d          = '0;
    s1_d.data     = PL_DW'(ch_data);
    s1_d.idx      = PL_IW'(enc_idx);
    s1_d.hit      = enc_hit;
    s1_d.byp_en   = byp_en;
    s1_d.byp_data = PL_DW'(byp_data);
  end

  // ---------------- flow control ----------------
  // Stage 2 moves when it is empty or being drained; stage 1 moves when
  // it is empty or stage 2 moves.
  logic adv2;
  logic adv1;

  assign out_valid = v2;
  assign adv2      = !v2 || out_ready;
  assign adv1      = !v1 || adv2;
  assign in_ready  = adv1;

  // ---------------- stage 2 resolve ----------------
  logic [W-1:0]  s1_dat;
  logic [W-1:0]  s1_bdat;
  logic [IW-1:0] s1_idx;
  logic          take_byp;

  assign s1_dat  = s1_q.data[W-1:0];
  assign s1_bdat = s1_q.byp_data[W-1:0];
  assign s1_idx  = s1_q.idx[IW-1:0];

  // late_ctrl is looked at only in the cycle the beat leaves stage 1.
  // A result held in stage 2 is already resolved, so later changes to late_ctrl cannot disturb it.
  assign take_byp = s1_q.byp_en && !late_ctrl &&
                    (!s1_q.hit || int'(s1_idx) >= BYP_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s1_q     <= '0;
      v2       <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
      out_hit  <= 1'b0;
      out_byp  <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          out_data <= take_byp ? s1_bdat : s1_dat;
          out_idx  <= s1_idx;
          out_hit  <= s1_q.hit;
          out_byp  <= take_byp;
        end
      end
    end
  end

  // ---------------- bypass counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_cnt <= '0;
    end else if (v2 && out_ready && out_byp && (byp_cnt != '1)) begin
      byp_cnt <= byp_cnt + CW'(SAT_INC);
    end
  end

  // Payload fields are sized for the widest build, so the upper bits are not read here.
  logic unused_pl_bits;
  assign unused_pl_bits = ^s1_q;

endmodule

// File: tb/tb_prio_sel_pipe.sv
module tb_prio_sel_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  sel;
  logic [31:0] data;
  logic [7:0]  dflt;
  logic        byp_en;
  logic [7:0]  byp_data;
  logic        late_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_hit;
  logic        out_byp;
  logic [15:0] byp_cnt;

  // Second instance built with a 2-bit counter and driven by the same inputs.
  logic        s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_data;
  logic [1:0]  s_out_idx;
  logic        s_out_hit;
  logic        s_out_byp;
  logic [1:0]  s_byp_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prio_sel_pipe #(.W(8), .N(4), .BYP_MIN(2), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data(data), .dflt(dflt), .byp_en(byp_en), .byp_data(byp_data),
    .late_ctrl(late_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_hit(out_hit), .out_byp(out_byp),
    .byp_cnt(byp_cnt)
  );

  prio_sel_pipe #(.W(8), .N(4), .BYP_MIN(2), .CW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .sel(sel), .data(data), .dflt(dflt), .byp_en(byp_en), .byp_data(byp_data),
    .late_ctrl(late_ctrl), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_idx(s_out_idx), .out_hit(s_out_hit), .out_byp(s_out_byp),
    .byp_cnt(s_byp_cnt)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] data;
    logic [7:0]  dflt;
    logic        byp_en;
    logic [7:0]  byp_data;
  } beat_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] idx;
    logic       hit;
    logic       byp;
  } res_t;

  // Reference: the first set bit counting up from 0 wins; bypass only if not vetoed
  // and the winner is absent or at index >= 2.
  function automatic res_t resolve(beat_t b, logic late);
    res_t r;
    bit   found;
    found = 1'b0;
    r.d   = b.dflt;
    r.idx = 2'd0;
    r.hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && b.sel[i]) begin
        found = 1'b1;
        r.hit = 1'b1;
        r.idx = 2'(i);
        r.d   = b.data[i*8 +: 8];
      end
    end
    r.byp = b.byp_en && !late && (!r.hit || r.idx >= 2'd2);
    if (r.byp) r.d = b.byp_data;
    return r;
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    sel       = '0;
    data      = '0;
    dflt      = '0;
    byp_en    = 1'b0;
    byp_data  = '0;
    late_ctrl = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Sends one beat, then holds late_ctrl at late2 during the cycle the beat
  // leaves stage 1. Returns at the first cycle the result should be valid.
  task automatic send_one(input logic [3:0] s, input logic [31:0] d, input logic [7:0] df,
                          input logic be, input logic [7:0] bd,
                          input logic late_acc, input logic late2);
    in_valid = 1'b1; sel = s; data = d; dflt = df; byp_en = be; byp_data = bd;
    late_ctrl = late_acc;
    @(posedge clk); #1;
    in_valid = 1'b0; sel = '0; byp_en = 1'b0; late_ctrl = late2;
    @(posedge clk); #1;
    late_ctrl = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_idx !== 2'd0 ||
        out_hit !== 1'b0 || out_byp !== 1'b0 || byp_cnt !== 16'd0 || s_byp_cnt !== 2'd0)
      begin errors++; $display("FAIL reset_outputs: got v=%b d=%h i=%0d h=%b b=%b cnt=%0d scnt=%0d, want all 0",
                               out_valid, out_data, out_idx, out_hit, out_byp, byp_cnt, s_byp_cnt); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_prio();
    do_reset();
    in_valid = 1'b1; sel = 4'b0110; data = 32'h33221100; dflt = 8'hEE;
    byp_en = 1'b0; byp_data = 8'h99;
    @(posedge clk); #1;
    in_valid = 1'b0; sel = '0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_latency1: got out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL prio_latency2: got out_valid=%b want 1", out_valid); end
    checks++;
    if (out_data !== 8'h11 || out_idx !== 2'd1 || out_hit !== 1'b1 || out_byp !== 1'b0)
      begin errors++; $display("FAIL prio_result: got d=%h i=%0d h=%b b=%b want d=11 i=1 h=1 b=0",
                               out_data, out_idx, out_hit, out_byp); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL prio_single: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_bypass();
    do_reset();
    send_one(4'b0100, 32'h33221100, 8'hEE, 1'b1, 8'hAA, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hAA || out_byp !== 1'b1 || out_idx !== 2'd2 || byp_cnt !== 16'd0)
      begin errors++; $display("FAIL byp_apply: got v=%b d=%h b=%b i=%0d cnt=%0d want v=1 d=aa b=1 i=2 cnt=0",
                               out_valid, out_data, out_byp, out_idx, byp_cnt); end
    @(posedge clk); #1;
    checks++;
    if (byp_cnt !== 16'd1) begin errors++; $display("FAIL byp_count: got %0d want 1", byp_cnt); end

    // Veto in the stage-2 cycle wins even though late_ctrl was low at acceptance.
    send_one(4'b0100, 32'h33221100, 8'hEE, 1'b1, 8'hAA, 1'b0, 1'b1);
    checks++;
    if (out_data !== 8'h22 || out_byp !== 1'b0)
      begin errors++; $display("FAIL byp_veto: got d=%h b=%b want d=22 b=0", out_data, out_byp); end
    @(posedge clk); #1;
    checks++;
    if (byp_cnt !== 16'd1) begin errors++; $display("FAIL byp_veto_count: got %0d want 1", byp_cnt); end

    // late_ctrl high only alongside the beat is ignored.
    send_one(4'b1000, 32'h33221100, 8'hEE, 1'b1, 8'hB7, 1'b1, 1'b0);
    checks++;
    if (out_data !== 8'hB7 || out_byp !== 1'b1 || out_idx !== 2'd3)
      begin errors++; $display("FAIL byp_late_timing: got d=%h b=%b i=%0d want d=b7 b=1 i=3",
                               out_data, out_byp, out_idx); end
    @(posedge clk); #1;

    // Winner below BYP_MIN is never bypassed.
    send_one(4'b0110, 32'h33221100, 8'hEE, 1'b1, 8'hAA, 1'b0, 1'b0);
    checks++;
    if (out_data !== 8'h11 || out_byp !== 1'b0)
      begin errors++; $display("FAIL byp_min: got d=%h b=%b want d=11 b=0", out_data, out_byp); end
    @(posedge clk); #1;
  endtask

  task automatic test_nohit();
    do_reset();
    send_one(4'b0000, 32'h33221100, 8'h5C, 1'b1, 8'h3C, 1'b0, 1'b0);
    checks++;
    if (out_data !== 8'h3C || out_hit !== 1'b0 || out_idx !== 2'd0 || out_byp !== 1'b1)
      begin errors++; $display("FAIL nohit_byp: got d=%h h=%b i=%0d b=%b want d=3c h=0 i=0 b=1",
                               out_data, out_hit, out_idx, out_byp); end
    @(posedge clk); #1;
    send_one(4'b0000, 32'h33221100, 8'h5C, 1'b0, 8'h3C, 1'b0, 1'b0);
    checks++;
    if (out_data !== 8'h5C || out_hit !== 1'b0 || out_byp !== 1'b0)
      begin errors++; $display("FAIL nohit_dflt: got d=%h h=%b b=%b want d=5c h=0 b=0",
                               out_data, out_hit, out_byp); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    logic [7:0] exp_q[$];
    logic [7:0] held;
    logic       was_stalled;
    int         sent;
    int         got;
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i*16 + (i % 4)));
    sent = 0; got = 0; was_stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      in_valid  = (sent < 8);
      sel       = 4'(1 << (sent % 4));
      data      = {8'(sent*16+3), 8'(sent*16+2), 8'(sent*16+1), 8'(sent*16)};
      byp_en    = 1'b0;
      late_ctrl = 1'($urandom_range(0, 1));
      out_ready = !(cyc >= 4 && cyc < 7);
      @(negedge clk);
      if (was_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held)
          begin errors++; $display("FAIL stall_stable: got v=%b d=%h want v=1 d=%h", out_valid, out_data, held); end
      end
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cyc %0d got %b want 0", cyc, in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== exp_q[got])
          begin errors++; $display("FAIL stall_order: beat %0d got %h want %h", got, out_data, exp_q[got]); end
        got++;
      end
      was_stalled = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++;
    if (got != 8) begin errors++; $display("FAIL stall_count: got %0d beats want 8", got); end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; sel = 4'b0000; dflt = 8'h01; byp_en = 1'b1; byp_data = 8'h5A;
    late_ctrl = 1'b0; out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0; byp_en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (s_byp_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d want 3", s_byp_cnt); end
    checks++;
    if (byp_cnt !== 16'd5) begin errors++; $display("FAIL wide_cnt: got %0d want 5", byp_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; sel = 4'b0001; data = 32'h00000077; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77)
      begin errors++; $display("FAIL mid_inflight: got v=%b d=%h want v=1 d=77", out_valid, out_data); end
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_hit !== 1'b0)
      begin errors++; $display("FAIL mid_reset_clear: got v=%b d=%h h=%b want 0", out_valid, out_data, out_hit); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: cycle %0d got out_valid=%b want 0", i, out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    beat_t     pend[$];
    res_t      res[$];
    beat_t     b;
    res_t      r;
    logic      exp_ready;
    logic      free;
    int        exp_cnt;
    int        exp_scnt;
    do_reset();
    exp_cnt = 0; exp_scnt = 0;
    for (int cyc = 0; cyc < 330; cyc++) begin
      b.sel      = 4'($urandom);
      b.data     = $urandom;
      b.dflt     = 8'($urandom);
      b.byp_en   = 1'($urandom);
      b.byp_data = 8'($urandom);
      in_valid   = (cyc < 300) && ($urandom_range(0, 9) < 7);
      out_ready  = (cyc >= 300) || ($urandom_range(0, 9) < 7);
      late_ctrl  = 1'($urandom);
      sel = b.sel; data = b.data; dflt = b.dflt; byp_en = b.byp_en; byp_data = b.byp_data;
      @(negedge clk);
      checks++;
      if (out_valid !== (res.size() != 0))
        begin errors++; $display("FAIL rnd_valid: cyc %0d got %b want %b", cyc, out_valid, res.size() != 0); end
      if (res.size() != 0) begin
        checks++;
        if (out_data !== res[0].d || out_idx !== res[0].idx || out_hit !== res[0].hit || out_byp !== res[0].byp)
          begin errors++; $display("FAIL rnd_result: cyc %0d got d=%h i=%0d h=%b b=%b want d=%h i=%0d h=%b b=%b",
                                   cyc, out_data, out_idx, out_hit, out_byp,
                                   res[0].d, res[0].idx, res[0].hit, res[0].byp); end
      end
      exp_ready = (pend.size() == 0) || (res.size() == 0) || out_ready;
      checks++;
      if (in_ready !== exp_ready)
        begin errors++; $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc, in_ready, exp_ready); end
      checks++;
      if (byp_cnt !== 16'(exp_cnt) || s_byp_cnt !== 2'(exp_scnt))
        begin errors++; $display("FAIL rnd_cnt: cyc %0d got %0d/%0d want %0d/%0d",
                                 cyc, byp_cnt, s_byp_cnt, exp_cnt, exp_scnt); end
      // Effect of the coming edge.
      free = (res.size() == 0) || out_ready;
      if (res.size() != 0 && out_ready) begin
        if (res[0].byp) begin
          exp_cnt++;
          if (exp_scnt != 3) exp_scnt++;
        end
        void'(res.pop_front());
      end
      if (free && pend.size() != 0) begin
        r = resolve(pend.pop_front(), late_ctrl);
        res.push_back(r);
      end
      if (in_valid && exp_ready) pend.push_back(b);
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++;
    if (pend.size() != 0 || res.size() != 0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL rnd_drain: pend=%0d res=%0d out_valid=%b want empty",
                               pend.size(), res.size(), out_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_prio();
    test_bypass();
    test_nohit();
    test_stall();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prio_sel_pipe.md
PRIO_SEL_PIPE -- requirements
Module: prio_sel_pipe

Interface
REQ-001 SHALL have parameter W, default 8: data width per channel.
REQ-002 SHALL have parameter N, default 4: number of select conditions/channels, 2..16.
REQ-003 SHALL have parameter BYP_MIN, default 2: lowest winning index at which bypass may override.
REQ-004 SHALL have parameter CW, default 16: width of the bypass event counter.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  input beat present.
REQ-008 SHALL have port in_ready  output  1  input beat accepted when in_valid&&in_ready.
REQ-009 SHALL have port sel  input  N  condition vector; bit 0 highest priority.
REQ-010 SHALL have port data  input  N*W  channel data; channel i at bits [i*W +: W].
REQ-011 SHALL have port dflt  input  W  value when no sel bit is set.
REQ-012 SHALL have port byp_en  input  1  bypass requested for this beat.
REQ-013 SHALL have port byp_data  input  W  bypass value.
REQ-014 SHALL have port late_ctrl  input  1  late-arriving veto; sampled in stage 2, not with the beat.
REQ-015 SHALL have port out_valid  output  1  result present.
REQ-016 SHALL have port out_ready  input  1  downstream accepts.
REQ-017 SHALL have port out_data  output  W  selected result.
REQ-018 SHALL have port out_idx  output  $clog2(N)  winning index; 0 when no hit.
REQ-019 SHALL have port out_hit  output  1  some sel bit was set.
REQ-020 SHALL have port out_byp  output  1  result came from bypass.
REQ-021 SHALL have port byp_cnt  output  CW  count of bypassed results delivered.

Function
REQ-022 Stage 1 SHALL register the lowest set sel index, its data (or dflt when none), hit flag, byp_en and byp_data on acceptance.
REQ-023 Stage 2 SHALL, on advance from stage 1, apply bypass iff byp_en_q && !late_ctrl && (!hit_q || idx_q >= BYP_MIN), using late_ctrl of the advancing cycle.
REQ-024 When bypass applies, out_data SHALL be byp_data_q and out_byp 1; otherwise out_data SHALL be the stage-1 value and out_byp 0.
REQ-025 Latency SHALL be exactly 2 cycles from acceptance to out_valid with no backpressure.
REQ-026 Each stage SHALL advance when empty or when the next stage advances; in_ready = !v1 || (!v2 || out_ready).
REQ-027 Full throughput SHALL be one beat per cycle with out_ready held high.
REQ-028 While out_valid && !out_ready, all outputs SHALL stay stable; late_ctrl changes SHALL not alter held results.
REQ-029 byp_cnt SHALL increment once per out_valid&&out_ready beat with out_byp=1 and saturate at all-ones.
REQ-030 Simultaneous accept and deliver SHALL be lossless and order-preserving.

Reset
REQ-031 On rst_n low, v1, v2, out_valid, out_data, out_idx, out_hit, out_byp, byp_cnt SHALL clear to 0 immediately; in_ready SHALL be 1 after reset release.
REQ-032 A reset mid-transfer SHALL discard in-flight beats; no output beat SHALL appear for them.

Structure
REQ-033 A shared package SHALL hold the stage-payload struct (data, idx, hit, byp_en, byp_data) and the saturating-increment constant.
REQ-034 The priority encoder SHALL be one sub-module, prio_enc, parametrised by N, outputting idx and hit.

Verification
REQ-035 sel=4'b0110, data ch1=0x11, ch2=0x22, byp_en=0 -> 2 cycles later out_data=0x11, out_idx=1, out_hit=1.
REQ-036 sel=4'b0100, byp_en=1, byp_data=0xAA, late_ctrl=0 in stage 2 -> out_data=0xAA, out_byp=1, byp_cnt 0->1.
REQ-037 Same as 036 but late_ctrl=1 in stage-2 cycle -> out_data=ch2 value, out_byp=0, byp_cnt unchanged.
REQ-038 sel=0, dflt=0x5C, byp_en=1, late_ctrl=0 -> out_data=byp_data, out_hit=0; with byp_en=0 -> out_data=0x5C.
REQ-039 Stream 8 beats, out_ready low 3 cycles mid-stream -> in_ready drops after 2 held beats, all 8 delivered in order, outputs stable while stalled.
REQ-040 byp_cnt preloaded near saturation via CW=2 build, 5 bypass beats -> byp_cnt=3; rst_n pulse mid-stream -> out_valid 0 immediately, no stale beat afterward.
